// File: rtl/lfsr_pkg.sv
// rtl/lfsr_pkg.sv - shared LFSR tap table, next-state function and checker state enum
package lfsr_pkg;

    localparam int MAX_BITS = 12;

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } state_t;

    // XNOR feedback taps (bit positions 0-based) for maximal-length sequences of width 3..12
    function automatic logic [MAX_BITS-1:0] tap_mask(input int nbits);
        logic [MAX_BITS-1:0] mask;
        case (nbits)
            3:       mask = 12'h006;
            4:       mask = 12'h00C;
            5:       mask = 12'h014;
            6:       mask = 12'h030;
            7:       mask = 12'h060;
            8:       mask = 12'h0B8;
            9:       mask = 12'h110;
            10:      mask = 12'h240;
            11:      mask = 12'h500;
            12:      mask = 12'h829;
            default: mask = 12'h00C;
        endcase
        return mask;
    endfunction

    function automatic logic [MAX_BITS-1:0] lfsr_next(input logic [MAX_BITS-1:0] cur, input int nbits);
        logic [MAX_BITS-1:0] keep;
        logic                fb;
        keep = (12'd1 << nbits) - 12'd1;
        fb   = ~^(cur & tap_mask(nbits));
        return {cur[MAX_BITS-2:0], fb} & keep;
    endfunction

endpackage

// File: rtl/lfsr_gen.sv
// rtl/lfsr_gen.sv - LFSR word generator sharing lfsr_next with the checker
module lfsr_gen
    import lfsr_pkg::*;
#(
    parameter int NUM_BITS = 4
) (
    input  logic                i_Clk,
    input  logic                i_Rst_L,
    input  logic                i_Enable,
    output logic [NUM_BITS-1:0] o_Data
);

    always_ff @(posedge i_Clk) begin
        if (!i_Rst_L) begin
            o_Data <= '0;
        end else if (i_Enable) begin
            o_Data <= NUM_BITS'(lfsr_next(MAX_BITS'(o_Data), NUM_BITS));
        end
    end

endmodule

// File: rtl/lfsr_checker.sv
// rtl/lfsr_checker.sv - locks onto a received LFSR word stream and counts mispredicted words
module lfsr_checker
    import lfsr_pkg::*;
#(
    parameter int NUM_BITS   = 4,
    parameter int LOCK_COUNT = 3,
    parameter int LOSS_COUNT = 3
) (
    input  logic                i_Clk,
    input  logic                i_Rst_L,
    input  logic                i_Data_DV,
    input  logic [NUM_BITS-1:0] i_Data,
    input  logic                i_Clear_Count,
    output logic                o_Locked,
    output logic                o_Error,
    output logic [15:0]         o_Error_Count,
    output logic                o_Wrap
);

    localparam logic [NUM_BITS-1:0] LOCKUP = '1;
    localparam logic [7:0]          LOCK_C = 8'(LOCK_COUNT);
    localparam logic [7:0]          LOSS_C = 8'(LOSS_COUNT);

    state_t              state;
    logic [NUM_BITS-1:0] pred;
    logic [NUM_BITS-1:0] anchor;
    logic [7:0]          match_cnt;
    logic [7:0]          miss_cnt;
    logic                hit;
    logic                err_now;

    function automatic logic [NUM_BITS-1:0] nxt(input logic [NUM_BITS-1:0] w);
        return NUM_BITS'(lfsr_next(MAX_BITS'(w), NUM_BITS));
    endfunction

    // The lockup word can never be a correct prediction, whatever pred holds
    assign hit     = (i_Data == pred) && (i_Data != LOCKUP);
    assign err_now = i_Data_DV && (state == LOCKED) && !hit;

    always_ff @(posedge i_Clk) begin
        if (!i_Rst_L) begin
            state         <= SEARCH;
            pred          <= '0;
            anchor        <= '0;
            match_cnt     <= '0;
            miss_cnt      <= '0;
            o_Locked      <= 1'b0;
            o_Error       <= 1'b0;
            o_Wrap        <= 1'b0;
            o_Error_Count <= '0;
        end else begin
            o_Error <= err_now;
            o_Wrap  <= 1'b0;

            if (i_Clear_Count) begin
                o_Error_Count <= '0;
            end else if (err_now && (o_Error_Count != 16'hFFFF)) begin
                o_Error_Count <= o_Error_Count + 16'd1;
            end

            if (i_Data_DV) begin
                case (state)
                    VERIFY: begin
                        if (hit) begin
                            pred <= nxt(i_Data);
                            if (match_cnt + 8'd1 == LOCK_C) begin
                                state    <= LOCKED;
                                o_Locked <= 1'b1;
                                anchor   <= i_Data;
                                miss_cnt <= '0;
                            end else begin
                                match_cnt <= match_cnt + 8'd1;
                            end
                        end else if (i_Data != LOCKUP) begin
                            pred      <= nxt(i_Data);
                            match_cnt <= '0;
                        end else begin
                            state <= SEARCH;
                        end
                    end
                    LOCKED: begin
                        // Free-run from the expected word so one bad word costs one error
                        pred <= nxt(pred);
                        if (hit) begin
                            miss_cnt <= '0;
                            o_Wrap   <= (i_Data == anchor);
                        end else if (miss_cnt + 8'd1 == LOSS_C) begin
                            state     <= SEARCH;
                            o_Locked  <= 1'b0;
                            miss_cnt  <= '0;
                            match_cnt <= '0;
                        end else begin
                            miss_cnt <= miss_cnt + 8'd1;
                        end
                    end
                    default: begin
                        if (i_Data != LOCKUP) begin
                            state     <= VERIFY;
                            pred      <= nxt(i_Data);
                            match_cnt <= '0;
                        end else begin
                            state <= SEARCH;
                        end
                    end
                endcase
            end
        end
    end

endmodule
